// File: rtl/galvo_scan_if.sv
// galvo_scan_if
// Bundles the controller-facing and DAC-facing signals of the galvo raster
// sequencer so they travel as a single port.
//   master modport : the master controller / bench side (drives enable, go,
//                    restart; observes SPI lines and status)
//   slave modport  : the galvo_scan sequencer itself
// Signals:
//   enable, galvo_go, scan_restart      controller requests
//   spi_csn, spi_sclk, spi_mosi         DAC serial link (CPOL=0, MSB first)
//   galvoh, galvov                      last committed position
//   galvo_spi_done, frame_done          one-cycle commit pulses
//   busy, overrun                       status
interface galvo_scan_if;
  logic        enable;
  logic        galvo_go;
  logic        scan_restart;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic [10:0] galvoh;
  logic [10:0] galvov;
  logic        galvo_spi_done;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  modport master (
    output enable, galvo_go, scan_restart,
    input  spi_csn, spi_sclk, spi_mosi, galvoh, galvov,
           galvo_spi_done, frame_done, busy, overrun
  );

  modport slave (
    input  enable, galvo_go, scan_restart,
    output spi_csn, spi_sclk, spi_mosi, galvoh, galvov,
           galvo_spi_done, frame_done, busy, overrun
  );
endinterface

// File: rtl/galvo_scan.sv
// galvo_scan
// Raster-scan sequencer for the two-axis galvo. Each accepted galvo_go sends
// the next H target (and the V target when it differs from the committed V,
// or on the first move after reset/restart) to the dual-channel DAC over SPI,
// then commits the position and advances the raster.
// Ports:
//   clk_adc  ADC sample clock, the only clock
//   rst_adc  synchronous active-high reset
//   bus      galvo_scan_if.slave (requests in, SPI lines and status out)
// All outputs come straight from flops.
module galvo_scan #(
  parameter int H_LAST  = 1023,
  parameter int V_LAST  = 1023,
  parameter int SPI_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic         clk_adc,
  input  logic         rst_adc,
  galvo_scan_if.slave  bus
);

  localparam int PH_W  = $clog2(2 * SPI_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SPI_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(SPI_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [10:0]      H_MAX    = 11'(H_LAST);
  localparam logic [10:0]      V_MAX    = 11'(V_LAST);

  typedef enum logic [2:0] {
    IDLE,
    H_SHIFT,
    GAP,
    V_SHIFT,
    COMMIT
  } state_t;

  state_t           r_state, w_stateNext;
  logic [PH_W-1:0]  r_phase, w_phaseNext;
  logic [3:0]       r_bit,   w_bitNext;
  logic [GAP_W-1:0] r_gap,   w_gapNext;
  logic [15:0]      r_word,  w_wordNext;
  logic             r_needV, w_needVNext;

  logic [10:0]      r_hTgt, r_vTgt;
  logic             r_first;

  logic             r_csn, r_sclk, r_mosi, r_busy;
  logic [10:0]      r_galvoh, r_galvov;
  logic             r_done, r_frame, r_overrun;

  logic             w_csnNext, w_sclkNext, w_mosiNext, w_busyNext, w_commitNext;
  logic             w_goAccept, w_bitEnd;

  assign w_goAccept = bus.galvo_go & bus.enable;
  assign w_bitEnd   = (r_phase == PH_LAST);

  // State register: FSM state plus the bit/phase/gap counters and the word
  // being shifted out.
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_word  <= '0;
      r_needV <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_phase <= w_phaseNext;
      r_bit   <= w_bitNext;
      r_gap   <= w_gapNext;
      r_word  <= w_wordNext;
      r_needV <= w_needVNext;
    end
  end

  // Next-state logic. Each bit is 2*SPI_DIV phases long; the phase counter
  // restarts at every bit, the bit counter walks 15 down to 0. The V word is
  // skipped when the mirror is already on the right row.
  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = r_phase;
    w_bitNext   = r_bit;
    w_gapNext   = r_gap;
    w_wordNext  = r_word;
    w_needVNext = r_needV;
    case (r_state)
      IDLE: begin
        if (w_goAccept) begin
          w_stateNext = H_SHIFT;
          w_phaseNext = '0;
          w_bitNext   = 4'd15;
          w_wordNext  = {5'b00000, r_hTgt};
          w_needVNext = (r_vTgt != r_galvov) | r_first;
        end
      end
      H_SHIFT, V_SHIFT: begin
        if (w_bitEnd) begin
          w_phaseNext = '0;
          if (r_bit == 4'd0) begin
            if ((r_state == H_SHIFT) && r_needV) begin
              w_stateNext = GAP;
              w_gapNext   = '0;
            end else begin
              w_stateNext = COMMIT;
            end
          end else begin
            w_bitNext = r_bit - 4'd1;
          end
        end else begin
          w_phaseNext = r_phase + PH_W'(1);
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_stateNext = V_SHIFT;
          w_phaseNext = '0;
          w_bitNext   = 4'd15;
          w_wordNext  = {5'b01000, r_vTgt};
        end else begin
          w_gapNext = r_gap + GAP_W'(1);
        end
      end
      COMMIT:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    // Restart wins over everything, including a simultaneous go.
    if (bus.scan_restart) begin
      w_stateNext = IDLE;
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe. sclk is low for the first half of a bit,
  // and mosi only moves at a bit boundary (phase 0, sclk low).
  always_comb begin
    w_csnNext    = 1'b1;
    w_sclkNext   = 1'b0;
    w_mosiNext   = 1'b0;
    w_busyNext   = (w_stateNext != IDLE);
    w_commitNext = (w_stateNext == COMMIT);
    if ((w_stateNext == H_SHIFT) || (w_stateNext == V_SHIFT)) begin
      w_csnNext  = 1'b0;
      w_sclkNext = (w_phaseNext >= PH_HIGH);
      w_mosiNext = w_wordNext[w_bitNext];
    end
  end

  // Output register for the SPI lines and busy.
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      r_csn  <= 1'b1;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_csn  <= w_csnNext;
      r_sclk <= w_sclkNext;
      r_mosi <= w_mosiNext;
      r_busy <= w_busyNext;
    end
  end

  // Commit and raster bookkeeping. The commit happens on the edge entering
  // COMMIT so the new position and the done pulse appear together in the
  // COMMIT cycle. Restart clears the raster but leaves the committed
  // position alone.
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      r_hTgt    <= '0;
      r_vTgt    <= '0;
      r_first   <= 1'b1;
      r_galvoh  <= '0;
      r_galvov  <= '0;
      r_done    <= 1'b0;
      r_frame   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done  <= w_commitNext;
      r_frame <= w_commitNext && (r_hTgt == H_MAX) && (r_vTgt == V_MAX);
      if (bus.scan_restart) begin
        r_hTgt    <= '0;
        r_vTgt    <= '0;
        r_first   <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        if (w_goAccept && (r_state != IDLE)) begin
          r_overrun <= 1'b1;
        end
        if (w_commitNext) begin
          r_galvoh <= r_hTgt;
          r_galvov <= r_vTgt;
          r_first  <= 1'b0;
          if (r_hTgt == H_MAX) begin
            r_hTgt <= '0;
            r_vTgt <= (r_vTgt == V_MAX) ? 11'd0 : r_vTgt + 11'd1;
          end else begin
            r_hTgt <= r_hTgt + 11'd1;
          end
        end
      end
    end
  end

  assign bus.spi_csn        = r_csn;
  assign bus.spi_sclk       = r_sclk;
  assign bus.spi_mosi       = r_mosi;
  assign bus.galvoh         = r_galvoh;
  assign bus.galvov         = r_galvov;
  assign bus.galvo_spi_done = r_done;
  assign bus.frame_done     = r_frame;
  assign bus.busy           = r_busy;
  assign bus.overrun        = r_overrun;

endmodule

// File: tb/tb_galvo_scan.sv
// tb_galvo_scan
// Bench for galvo_scan with a 4x2 raster (H_LAST=3, V_LAST=1), SPI_DIV=2,
// CS_GAP=4. A cycle-level reference model derives every output from the
// transfer timeline (cycle number since the accepted go), a compare process
// checks it at each falling edge, and a mosi decoder rebuilds the DAC words
// for the directed scenarios. A randomized phase finishes the run.
module tb_galvo_scan;

  localparam int HL = 3;
  localparam int VL = 1;
  localparam int D  = 2;
  localparam int G  = 4;
  localparam int W  = 32 * D;

  logic clock;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;

  galvo_scan_if bus ();

  galvo_scan #(
    .H_LAST (HL),
    .V_LAST (VL),
    .SPI_DIV(D),
    .CS_GAP (G)
  ) dut (
    .clk_adc(clock),
    .rst_adc(reset),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state
  bit          mActive = 0;
  int          mK = 0;
  int          mEnd = 0;
  bit          mNeedV = 0;
  logic [10:0] mH = '0, mV = '0, mGalvoH = '0, mGalvoV = '0;
  bit          mFirst = 1;
  bit          mOverrun = 0;
  logic [15:0] mHWord = '0, mVWord = '0;
  bit          eCsn = 1, eSclk = 0, eMosi = 0, eDone = 0, eFrame = 0, eBusy = 0;

  // Decoded DAC words
  logic [15:0] rxShift = '0;
  int          rxCount = 0;
  logic [15:0] rxWords[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("[TB] FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Model: at each rising edge, apply the sampled inputs and work out what
  // every output must be during the cycle that follows.
  always @(posedge clock) begin : modelProc
    int          j;
    logic [15:0] word;
    bit          shifting;
    eDone  = 0;
    eFrame = 0;
    if (reset) begin
      mActive = 0; mH = '0; mV = '0; mFirst = 1;
      mGalvoH = '0; mGalvoV = '0; mOverrun = 0;
    end else if (bus.scan_restart) begin
      mActive = 0; mH = '0; mV = '0; mFirst = 1; mOverrun = 0;
    end else if (mActive) begin
      if (bus.galvo_go && bus.enable) mOverrun = 1;
      if (mK == mEnd) begin
        mActive = 0;
      end else begin
        mK++;
        if (mK == mEnd) begin
          eDone   = 1;
          eFrame  = (int'(mH) == HL) && (int'(mV) == VL);
          mGalvoH = mH;
          mGalvoV = mV;
          mFirst  = 0;
          if (int'(mH) == HL) begin
            mH = '0;
            mV = (int'(mV) == VL) ? 11'd0 : mV + 11'd1;
          end else begin
            mH = mH + 11'd1;
          end
        end
      end
    end else if (bus.galvo_go && bus.enable) begin
      mActive = 1;
      mK      = 1;
      mNeedV  = (mV != mGalvoV) || mFirst;
      mHWord  = {5'b0, mH};
      mVWord  = 16'h4000 | {5'b0, mV};
      mEnd    = mNeedV ? (2 * W + G + 1) : (W + 1);
    end
    eBusy = mActive;
    eCsn  = 1; eSclk = 0; eMosi = 0;
    shifting = 0;
    j = 0;
    word = '0;
    if (mActive && mK != mEnd) begin
      if (mK <= W) begin
        j = mK - 1; word = mHWord; shifting = 1;
      end else if (mK > W + G) begin
        j = mK - W - G - 1; word = mVWord; shifting = 1;
      end
    end
    if (shifting) begin
      eCsn  = 0;
      eSclk = (j % (2 * D)) >= D;
      eMosi = word[15 - j / (2 * D)];
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clock) begin
    checkOutput("csn",      bus.spi_csn,        eCsn);
    checkOutput("sclk",     bus.spi_sclk,       eSclk);
    checkOutput("mosi",     bus.spi_mosi,       eMosi);
    checkOutput("galvoh",   bus.galvoh,         mGalvoH);
    checkOutput("galvov",   bus.galvov,         mGalvoV);
    checkOutput("done",     bus.galvo_spi_done, eDone);
    checkOutput("frameDone", bus.frame_done,    eFrame);
    checkOutput("busy",     bus.busy,           eBusy);
    checkOutput("overrun",  bus.overrun,        mOverrun);
  end

  // mosi decoder: sample on sclk rising edges while csn is low.
  always @(negedge bus.spi_csn) rxCount = 0;
  always @(posedge bus.spi_sclk) begin
    if (!bus.spi_csn) begin
      rxShift = {rxShift[14:0], bus.spi_mosi};
      rxCount++;
      if (rxCount == 16) rxWords.push_back(rxShift);
    end
  end

  // One-cycle go pulse, sampled at the second rising edge after the call.
  task automatic applyStimulus();
    @(posedge clock); #1 bus.galvo_go = 1'b1;
    @(posedge clock); #1 bus.galvo_go = 1'b0;
  endtask

  task automatic runMove(input int nWords, input logic [15:0] w0, input logic [15:0] w1,
                         input int doneAt, input int eh, input int ev, input int ef,
                         input int extraGoAt);
    int n;
    bit seen;
    rxWords.delete();
    applyStimulus();
    n = 0;
    seen = 0;
    while (n < 400 && !seen) begin
      @(negedge clock);
      n++;
      if (bus.galvo_spi_done) begin
        seen = 1;
        checkOutput("moveGalvoH", bus.galvoh, eh);
        checkOutput("moveGalvoV", bus.galvov, ev);
        checkOutput("moveFrame",  bus.frame_done, ef);
      end else if (n == extraGoAt) begin
        bus.galvo_go = 1'b1;
        @(posedge clock); #1 bus.galvo_go = 1'b0;
      end
    end
    checkOutput("doneCycle", n, doneAt);
    checkOutput("wordCount", rxWords.size(), nWords);
    if (rxWords.size() >= 1) checkOutput("word0", rxWords[0], w0);
    if (nWords == 2 && rxWords.size() >= 2) checkOutput("word1", rxWords[1], w1);
  endtask

  task automatic runAbort(input bit useReset, input int eh, input int ev);
    applyStimulus();
    repeat (30) @(negedge clock);
    checkOutput("abortCsnLowBefore", bus.spi_csn, 0);
    if (useReset) reset = 1'b1;
    else bus.scan_restart = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    bus.scan_restart = 1'b0;
    @(negedge clock);
    checkOutput("abortCsn",    bus.spi_csn, 1);
    checkOutput("abortSclk",   bus.spi_sclk, 0);
    checkOutput("abortMosi",   bus.spi_mosi, 0);
    checkOutput("abortDone",   bus.galvo_spi_done, 0);
    checkOutput("abortBusy",   bus.busy, 0);
    checkOutput("abortGalvoH", bus.galvoh, eh);
    checkOutput("abortGalvoV", bus.galvov, ev);
    checkOutput("abortOverrun", bus.overrun, 0);
    checkOutput("abortFrame",  bus.frame_done, 0);
    repeat (5) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.galvo_go = 1'b0;
    bus.scan_restart = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rstCsn",     bus.spi_csn, 1);
    checkOutput("rstSclk",    bus.spi_sclk, 0);
    checkOutput("rstMosi",    bus.spi_mosi, 0);
    checkOutput("rstGalvoH",  bus.galvoh, 0);
    checkOutput("rstGalvoV",  bus.galvov, 0);
    checkOutput("rstDone",    bus.galvo_spi_done, 0);
    checkOutput("rstFrame",   bus.frame_done, 0);
    checkOutput("rstBusy",    bus.busy, 0);
    checkOutput("rstOverrun", bus.overrun, 0);

    bus.enable = 1'b1;
    // First move sends both words, then a row of H-only moves
    runMove(2, 16'h0000, 16'h4000, 133, 0, 0, 0, 0);
    runMove(1, 16'h0001, 16'h0000, 65, 1, 0, 0, 0);
    runMove(1, 16'h0002, 16'h0000, 65, 2, 0, 0, 0);
    runMove(1, 16'h0003, 16'h0000, 65, 3, 0, 0, 0);
    // Row wrap
    runMove(2, 16'h0000, 16'h4001, 133, 0, 1, 0, 0);
    runMove(1, 16'h0001, 16'h0000, 65, 1, 1, 0, 0);
    runMove(1, 16'h0002, 16'h0000, 65, 2, 1, 0, 0);
    // Last point of the frame
    runMove(1, 16'h0003, 16'h0000, 65, 3, 1, 1, 0);
    // Frame wrap
    runMove(2, 16'h0000, 16'h4000, 133, 0, 0, 0, 0);
    // Overrun: extra go at cycle 10 leaves the transfer untouched
    runMove(1, 16'h0001, 16'h0000, 65, 1, 0, 0, 10);
    @(negedge clock);
    checkOutput("overrunSet", bus.overrun, 1);
    // Go with enable low does nothing
    bus.enable = 1'b0;
    applyStimulus();
    repeat (20) @(negedge clock);
    checkOutput("disabledBusy",    bus.busy, 0);
    checkOutput("disabledCsn",     bus.spi_csn, 1);
    checkOutput("disabledOverrun", bus.overrun, 1);
    bus.enable = 1'b1;
    // Restart clears overrun and the raster
    @(posedge clock); #1 bus.scan_restart = 1'b1;
    @(posedge clock); #1 bus.scan_restart = 1'b0;
    @(negedge clock);
    checkOutput("restartOverrun", bus.overrun, 0);
    runMove(2, 16'h0000, 16'h4000, 133, 0, 0, 0, 0);
    runMove(1, 16'h0001, 16'h0000, 65, 1, 0, 0, 0);
    // Abort by restart keeps the committed position
    runAbort(1'b0, 1, 0);
    runMove(2, 16'h0000, 16'h4000, 133, 0, 0, 0, 0);
    runMove(1, 16'h0001, 16'h0000, 65, 1, 0, 0, 0);
    // Abort by reset returns everything to reset values
    runAbort(1'b1, 0, 0);
    runMove(2, 16'h0000, 16'h4000, 133, 0, 0, 0, 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      bus.galvo_go     = ($urandom_range(0, 29) == 0);
      bus.enable       = ($urandom_range(0, 9) != 0);
      bus.scan_restart = ($urandom_range(0, 399) == 0);
      reset            = ($urandom_range(0, 799) == 0);
    end
    @(posedge clock); #1;
    bus.galvo_go = 1'b0;
    bus.scan_restart = 1'b0;
    reset = 1'b0;
    repeat (150) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
